capp_core: RTL and testbench

Parametrised content-addressable parallel processor core. It merges the comparand/mask register, the word array, and the tag register with select-first and some/none into one block. A single valid/ready command port drives it. It adds three things the earlier split compare/cells/tags arrangement does not have:

- parametrised width and depth
- a READ response path
- a multi-cycle COUNT of responders

The core sits between the host sequencer and the associative word store.

---
 rtl/capp_core.sv | 202 ++++++++++++++++++++
 tb/tb_capp_core.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capp_core.sv
// capp_core: content-addressable parallel processor core.
// Holds the comparand/mask latch, the word array and the tag register.
// One valid/ready command port drives the core. READ and COUNT return
// their result on a one-cycle rsp_valid pulse.
module capp_core #(
  parameter int WIDTH = 32,
  parameter int WORDS = 100,
  parameter int LANES = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd_op,
  input  logic [WIDTH-1:0]             cmd_comparand,
  input  logic [WIDTH-1:0]             cmd_mask,
  output logic                         rsp_valid,
  output logic [WIDTH-1:0]             rsp_data,
  output logic [WORDS-1:0]             tags,
  output logic                         some_none,
  output logic [$clog2(WORDS+1)-1:0]   first_index
);

  localparam int IW     = $clog2(WORDS + 1);
  localparam int NCHUNK = (WORDS + LANES - 1) / LANES;
  localparam int CIW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PADW   = NCHUNK * LANES;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_SET    = 3'd1;
  localparam logic [2:0] OP_CLEAR  = 3'd2;
  localparam logic [2:0] OP_SEARCH = 3'd3;
  localparam logic [2:0] OP_SELFST = 3'd4;
  localparam logic [2:0] OP_WRITE  = 3'd5;
  localparam logic [2:0] OP_READ   = 3'd6;
  localparam logic [2:0] OP_COUNT  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CNT  = 2'd2
  } state_t;

  state_t             state_r;
  logic [2:0]         op_r;
  logic [WIDTH-1:0]   comparand_r;
  logic [WIDTH-1:0]   mask_r;
  logic [WIDTH-1:0]   words_r [WORDS];
  logic [WORDS-1:0]   tags_r;
  logic               some_none_r;
  logic               rsp_valid_r;
  logic [WIDTH-1:0]   rsp_data_r;
  logic [IW-1:0]      acc_r;
  logic [CIW-1:0]     idx_r;

  logic [IW-1:0]      first_idx_s;
  logic [WIDTH-1:0]   first_word_s;
  logic [WORDS-1:0]   first_hot_s;
  logic [WORDS-1:0]   tags_nxt_s;
  logic [PADW-1:0]    tags_pad_s;
  logic [IW-1:0]      chunk_cnt_s;

  // Number of set bits in one lane group of tags.
  function automatic logic [IW-1:0] lane_popcount(input logic [LANES-1:0] bits);
    logic [IW-1:0] sum;
    sum = {IW{1'b0}};
    for (int l = 0; l < LANES; l++) begin
      sum = sum + IW'(bits[l]);
    end
    return sum;
  endfunction

  // Priority-encode the lowest set tag: its index, its word and its one-hot.
  always_comb begin
    first_idx_s  = IW'(WORDS);
    first_word_s = {WIDTH{1'b0}};
    first_hot_s  = {WORDS{1'b0}};
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (tags_r[i]) begin
        first_idx_s    = IW'(i);
        first_word_s   = words_r[i];
        first_hot_s    = {WORDS{1'b0}};
        first_hot_s[i] = 1'b1;
      end else begin
        first_idx_s = first_idx_s;
      end
    end
  end

  // Next tag value; tags only change in the EXEC cycle of a tag-modifying op.
  always_comb begin
    tags_nxt_s = tags_r;
    if (state_r == ST_EXEC) begin
      case (op_r)
        OP_SET:    tags_nxt_s = {WORDS{1'b1}};
        OP_CLEAR:  tags_nxt_s = {WORDS{1'b0}};
        OP_SEARCH: begin
          for (int i = 0; i < WORDS; i++) begin
            tags_nxt_s[i] = tags_r[i] &
                            (((words_r[i] ^ comparand_r) & mask_r) == {WIDTH{1'b0}});
          end
        end
        OP_SELFST: tags_nxt_s = first_hot_s;
        default:   tags_nxt_s = tags_r;
      endcase
    end else begin
      tags_nxt_s = tags_r;
    end
  end

  // Popcount of the current COUNT chunk; padding above WORDS reads as zero.
  always_comb begin
    tags_pad_s  = PADW'(tags_r);
    chunk_cnt_s = lane_popcount(tags_pad_s[int'(idx_r) * LANES +: LANES]);
  end

  // Command FSM, tag register, responder count and response outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_NOP;
      comparand_r <= {WIDTH{1'b0}};
      mask_r      <= {WIDTH{1'b0}};
      tags_r      <= {WORDS{1'b0}};
      some_none_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {WIDTH{1'b0}};
      acc_r       <= {IW{1'b0}};
      idx_r       <= {CIW{1'b0}};
    end else begin
      rsp_valid_r <= 1'b0;
      tags_r      <= tags_nxt_s;
      some_none_r <= |tags_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_r        <= cmd_op;
            comparand_r <= cmd_comparand;
            mask_r      <= cmd_mask;
            state_r     <= ST_EXEC;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (op_r == OP_COUNT) begin
            acc_r   <= {IW{1'b0}};
            idx_r   <= {CIW{1'b0}};
            state_r <= ST_CNT;
          end else if (op_r == OP_READ) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= first_word_s;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CNT: begin
          acc_r <= acc_r + chunk_cnt_s;
          idx_r <= idx_r + {{(CIW-1){1'b0}}, 1'b1};
          if (idx_r == CIW'(NCHUNK - 1)) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= WIDTH'(acc_r + chunk_cnt_s);
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_CNT;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Masked write into every tagged word during the EXEC cycle of WRITE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < WORDS; i++) begin
        words_r[i] <= {WIDTH{1'b0}};
      end
    end else if (state_r == ST_EXEC && op_r == OP_WRITE) begin
      for (int i = 0; i < WORDS; i++) begin
        if (tags_r[i]) begin
          words_r[i] <= (words_r[i] & ~mask_r) | (comparand_r & mask_r);
        end else begin
          words_r[i] <= words_r[i];
        end
      end
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        words_r[i] <= words_r[i];
      end
    end
  end

  assign cmd_ready   = (state_r == ST_IDLE);
  assign rsp_valid   = rsp_valid_r;
  assign rsp_data    = rsp_data_r;
  assign tags        = tags_r;
  assign some_none   = some_none_r;
  assign first_index = first_idx_s;

endmodule

// File: tb/tb_capp_core.sv
// Testbench for capp_core: directed scenarios plus random commands, checked
// against a word/tag array model through a response scoreboard.
module tb_capp_core;

  localparam int WIDTH = 32;
  localparam int WORDS = 100;
  localparam int LANES = 8;
  localparam int IW    = $clog2(WORDS + 1);
  localparam int NCH   = (WORDS + LANES - 1) / LANES;
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_op = 3'd0;
  logic [WIDTH-1:0]  cmd_comparand = '0;
  logic [WIDTH-1:0]  cmd_mask = '0;
  logic              rsp_valid;
  logic [WIDTH-1:0]  rsp_data;
  logic [WORDS-1:0]  tags;
  logic              some_none;
  logic [IW-1:0]     first_index;

  capp_core #(.WIDTH(WIDTH), .WORDS(WORDS), .LANES(LANES)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_comparand(cmd_comparand), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .tags(tags), .some_none(some_none), .first_index(first_index)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               cyc;
  } exp_t;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] m_words [WORDS];
  logic [WORDS-1:0] m_tags;
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cnt  = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [WORDS-1:0] act, input logic [WORDS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int m_first();
    for (int i = 0; i < WORDS; i++) if (m_tags[i]) return i;
    return WORDS;
  endfunction

  task automatic m_clear();
    m_tags = '0;
    for (int i = 0; i < WORDS; i++) m_words[i] = '0;
    sb_q.delete();
  endtask

  // Reference behaviour of one accepted command; n is the acceptance cycle.
  task automatic m_apply(input logic [2:0] op, input logic [WIDTH-1:0] c,
                         input logic [WIDTH-1:0] m, input int n);
    exp_t e;
    int   f;
    case (op)
      3'd1: m_tags = '1;
      3'd2: m_tags = '0;
      3'd3: for (int i = 0; i < WORDS; i++)
              m_tags[i] = m_tags[i] & (((m_words[i] ^ c) & m) == '0);
      3'd4: begin f = m_first(); m_tags = '0; if (f < WORDS) m_tags[f] = 1'b1; end
      3'd5: for (int i = 0; i < WORDS; i++)
              if (m_tags[i]) m_words[i] = (m_words[i] & ~m) | (c & m);
      3'd6: begin
        f = m_first();
        e.data = (f < WORDS) ? m_words[f] : '0;
        e.cyc  = n + 1;
        sb_q.push_back(e);
      end
      3'd7: begin
        e.data = WIDTH'($countones(m_tags));
        e.cyc  = n + 1 + NCH;
        sb_q.push_back(e);
      end
      default: ;
    endcase
  endtask

  // Acceptance observer: sees the handshake at the negedge, updates the model after the edge.
  always begin : accept_proc
    logic [2:0]       a_op;
    logic [WIDTH-1:0] a_c, a_m;
    @(negedge CLK);
    if (!RST && cmd_valid && cmd_ready) begin
      a_op = cmd_op; a_c = cmd_comparand; a_m = cmd_mask;
      @(posedge CLK);
      #1;
      if (!RST) begin
        acc_cnt++;
        m_apply(a_op, a_c, a_m, cyc);
      end
    end
  end

  // Response monitor: every rsp_valid pulse must match the oldest expected response.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && rsp_valid) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got data %h at cycle %0d, expected no response", rsp_data, cyc);
      end else begin
        e = sb_q.pop_front();
        if (rsp_data !== e.data || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL rsp_data: got %h at cycle %0d, expected %h at cycle %0d",
                   rsp_data, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] m);
    int t = 0;
    @(posedge CLK); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_comparand = c; cmd_mask = m;
    @(negedge CLK);
    while (!cmd_ready && t < 100) begin @(negedge CLK); t++; end
    if (!cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout: cmd_ready stayed 0, expected 1 within 100 cycles");
      cmd_valid = 1'b0;
    end else begin
      @(posedge CLK); #2;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic check_state(input string nm);
    int t = 0;
    @(negedge CLK);
    while (!cmd_ready && t < 100) begin @(negedge CLK); t++; end
    chk({nm, "_ready"}, WORDS'(cmd_ready), WORDS'(1'b1));
    chk({nm, "_tags"}, tags, m_tags);
    chk({nm, "_some_none"}, WORDS'(some_none), WORDS'(|m_tags));
    chk({nm, "_first_index"}, WORDS'(first_index), WORDS'(m_first()));
  endtask

  task automatic reset_checks(input string nm);
    chk({nm, "_tags"}, tags, '0);
    chk({nm, "_some_none"}, WORDS'(some_none), '0);
    chk({nm, "_ready"}, WORDS'(cmd_ready), WORDS'(1'b1));
    chk({nm, "_rsp_valid"}, WORDS'(rsp_valid), '0);
    chk({nm, "_rsp_data"}, WORDS'(rsp_data), '0);
    chk({nm, "_first_index"}, WORDS'(first_index), WORDS'(100));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, low;
    logic [WIDTH-1:0] c, m;
    m_clear();

    // 1. Reset.
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    reset_checks("reset");
    @(posedge CLK); #1; RST = 1'b0;

    // 2. Write-all and count.
    issue(3'd1, '0, '0);
    issue(3'd5, '0, ONES);
    issue(3'd3, '0, ONES);
    check_state("writeall");
    chk("writeall_all_ones", tags, {WORDS{1'b1}});
    issue(3'd7, '0, '0);
    check_state("count100");

    // 3. Fill loop: word i-1 <= i.
    for (int i = 1; i <= WORDS; i++) begin
      issue(3'd1, '0, '0);
      issue(3'd3, '0, ONES);
      issue(3'd4, '0, '0);
      issue(3'd5, WIDTH'(i), ONES);
    end
    issue(3'd1, '0, '0);
    issue(3'd3, 32'd35, ONES);
    check_state("fill35");
    chk("fill35_index", WORDS'(first_index), WORDS'(34));
    issue(3'd6, '0, '0);
    check_state("read35");

    // 4. Masked search after fill.
    issue(3'd1, '0, '0);
    issue(3'd3, 32'h20, 32'h20);
    issue(3'd7, '0, '0);
    check_state("masked_count");
    issue(3'd4, '0, '0);
    issue(3'd6, '0, '0);
    check_state("masked_read");

    // Handshake: valid held for SET then SEARCH.
    @(posedge CLK); #1;
    a0 = acc_cnt;
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_comparand = '0; cmd_mask = '0;
    @(negedge CLK); chk("hs_ready_set", WORDS'(cmd_ready), WORDS'(1'b1));
    @(posedge CLK); #2;
    cmd_op = 3'd3; cmd_comparand = 32'd7; cmd_mask = ONES;
    @(negedge CLK); chk("hs_ready_busy", WORDS'(cmd_ready), '0);
    @(posedge CLK); #2;
    @(negedge CLK); chk("hs_ready_search", WORDS'(cmd_ready), WORDS'(1'b1));
    @(posedge CLK); #2;
    cmd_valid = 1'b0;
    chk("hs_alternate_accepts", WORDS'(acc_cnt - a0), WORDS'(2));
    check_state("hs_search");

    // Handshake: valid held through COUNT, then a NOP waits behind it.
    @(posedge CLK); #1;
    a0 = acc_cnt;
    cmd_valid = 1'b1; cmd_op = 3'd7;
    @(posedge CLK); #2;
    cmd_op = 3'd0;
    low = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (cmd_ready) break;
      low++;
    end
    chk("hs_count_ready_low", WORDS'(low), WORDS'(1 + NCH));
    chk("hs_count_single_accept", WORDS'(acc_cnt - a0), WORDS'(1));
    @(posedge CLK); #2;
    cmd_valid = 1'b0;
    chk("hs_nop_after_count", WORDS'(acc_cnt - a0), WORDS'(2));
    chk("hs_rsp_before_next", WORDS'(sb_q.size()), '0);

    // 5. Reset mid-COUNT: pending response dropped, array and tags cleared.
    issue(3'd1, '0, '0);
    issue(3'd7, '0, '0);
    repeat (2) @(posedge CLK);
    #1; RST = 1'b1; m_clear();
    repeat (3) @(negedge CLK);
    reset_checks("midcount_reset");
    @(posedge CLK); #1; RST = 1'b0;
    repeat (NCH + 4) @(negedge CLK);
    check_state("after_reset");
    issue(3'd1, '0, '0);
    issue(3'd3, '0, ONES);
    check_state("after_reset_zero_words");
    issue(3'd7, '0, '0);
    issue(3'd6, '0, '0);
    check_state("after_reset_count");

    // Random commands against the model.
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0: m = ONES;
        1: m = 32'h0000_000F;
        2: m = '0;
        default: m = $urandom;
      endcase
      c = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(0, 15)) : $urandom;
      issue(3'($urandom_range(0, 7)), c, m);
      check_state("rand");
    end

    repeat (NCH + 4) @(negedge CLK);
    chk("scoreboard_drained", WORDS'(sb_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
